fifo_drain_arb: RTL and testbench
=================================

Name: fifo_drain_arb

Overview:
- Round-robin readout controller for NCH receive FIFOs; each FIFO has a Wishbone-style slave read port, a fill count and an overflow flag.
- Polls the fill counts and grants one channel at a time.
- Issues single-word read strobes paced to the FIFO's registered pipeline and forwards each word with its channel tag to a single ready/valid output.
- An overflowed channel is recovered by a write strobe, which clears that FIFO.

Parameters:
- NCH, 4: number of FIFO channels (1..16).
- CHW, 2: channel index width, equals clog2(NCH) with minimum 1.
- MAXBURST, 16: maximum words read per grant (1..255).
- GAP, 3: idle cycles after each ack before the next strobe; covers the FIFO address advance and data re-register.
- HOLDOFF, 2: cycles after a burst before the same channel's fifocnt is trusted again.

Ports:
- wb_clk, in, 1: single clock; all logic is on the rising edge.
- wb_rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: when 0, no new grants; the current burst finishes.
- fifocnt, in, 16*NCH: per-channel fill count in 32-bit words.
- overflow, in, NCH: per-channel overflow flag.
- wb_cyc, out, NCH: per-channel cycle.
- wb_stb, out, NCH: per-channel strobe.
- wb_we, out, NCH: per-channel write enable; 1 means FIFO clear.
- wb_ack, in, NCH: per-channel acknowledge.
- wb_dat_i, in, 32*NCH: per-channel read data.
- out_dat, out, 32: forwarded word.
- out_ch, out, CHW: source channel of out_dat.
- out_vld, out, 1: output valid.
- out_rdy, in, 1: output ready.
- ovf_cnt, out, 16: saturating count of overflow recoveries.
- busy, out, 1: 1 in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; ptr=0; wb_cyc/stb/we=0; out_vld=0; out_dat=0; out_ch=0; ovf_cnt=0; holdoff counters=0.
- IDLE: if enable is 1, go to SCAN.
- SCAN, one cycle: search channels starting at ptr, wrapping modulo NCH. A channel is eligible when its holdoff is 0 and either overflow=1 or fifocnt!=0.
  - First eligible channel with overflow=1: go to CLEAR.
  - First eligible channel otherwise: latch budget = min(fifocnt, MAXBURST) and go to STROBE.
  - No eligible channel: go to IDLE.
  - Overflow takes priority over data on the same channel.
- STROBE: enter only when out_vld=0, or when out_vld=1 and out_rdy=1 in the same cycle.
  - Assert cyc=stb=1, we=0 on the granted channel and hold until wb_ack.
  - In the ack cycle: drop cyc/stb, capture wb_dat_i into out_dat, set out_ch and out_vld=1, budget--.
  - If budget is still non-zero, go to GAP; otherwise go to DONE.
- GAP: count GAP cycles, then go to STROBE.
  - If the output is still stalled, wait in STROBE with stb low.
- CLEAR: assert cyc=stb=we=1 until ack; then drop them, ovf_cnt++ (saturates at 16'hFFFF), and go to DONE.
  - No data is forwarded for a cleared channel; its contents are lost by design.
- DONE: load holdoff[ch]=HOLDOFF+GAP, set ptr=ch+1 mod NCH, go to SCAN (or IDLE if enable=0).
- Holdoff counters decrement every cycle while non-zero.
- Output:
  - out_vld clears on an out_vld&&out_rdy handshake unless a new word is captured in the same cycle.
  - out_dat and out_ch are stable while out_vld=1 and out_rdy=0.
- The live fifocnt is ignored during a burst; only the latched budget is used. This prevents over-reading on stale counts.
- Only one channel's cyc/stb is ever high. The strobe is never dropped before ack and never reasserted without a GAP.
- overflow rising mid-burst: the burst completes, and the channel is cleared on its next grant.
- Minimum read period is 2+GAP cycles per word.

Optional Feature:
- Macro DRAIN_HDR_EN.
- When defined: before the first data word of every burst, emit one header word {8'hA5, 4'h0, 4'(ch), 8'h00, 8'(budget)} with out_ch=ch, using the same handshake.
- When defined: an overflow recovery emits header {8'hA5, 4'h1, 4'(ch), 16'h0000}.
- When undefined: no header words; data words only.

Decomposition:
- Package fifo_drain_pkg: state enum (IDLE, SCAN, STROBE, GAP, CLEAR, DONE); header magic 8'hA5; header type codes.
- Sub-module rr_pick: combinational round-robin first-eligible finder (eligible vector, ptr -> idx, found). It is reused by other arbiters.

Test Plan:
- NCH=4, ch2 fifocnt=3, others 0, out_rdy=1 -> exactly 3 strobes on ch2 only, with at least GAP+1 cycles between acks; out_ch=2; data order preserved.
- ch0 fifocnt=40, MAXBURST=16 -> burst of 16, then grant to the next eligible channel; ch0 is regranted only after other channels and holdoff.
- ch1 and ch3 both non-zero, ptr=2 -> ch3 is served first, then ch1.
- out_rdy=0 for 20 cycles mid-burst -> out_dat held, no new strobe, no words lost or duplicated.
- ch0 overflow=1, fifocnt=5 -> one write strobe (we=1), ovf_cnt=1, no data forwarded.
- wb_rst_n pulled low during STROBE -> all strobes drop immediately, out_vld=0, ovf_cnt=0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared states, header codes and header builder for the FIFO drain arbiter
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_STROBE,
        ST_GAP,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam logic [7:0] HDR_MAGIC      = 8'hA5;
    localparam logic [3:0] HDR_TYPE_DATA  = 4'h0;
    localparam logic [3:0] HDR_TYPE_CLEAR = 4'h1;

    function automatic logic [31:0] make_hdr(input logic [3:0] typ,
                                             input logic [3:0] ch,
                                             input logic [15:0] tail);
        return {HDR_MAGIC, typ, ch, tail};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set bit of elig at or after ptr, wrapping
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        logic [W-1:0] c;
        c     = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            c = W'((int'(ptr) + i) % N);
            if (!found && elig[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arb.sv
// rtl/fifo_drain_arb.sv - round-robin readout of NCH Wishbone FIFOs into one ready/valid stream
// Optional burst/clear header words are emitted when DRAIN_HDR_EN is defined.
module fifo_drain_arb
    import fifo_drain_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CHW      = 2,
    parameter int MAXBURST = 16,
    parameter int GAP      = 3,
    parameter int HOLDOFF  = 2
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                enable,
    input  logic [16*NCH-1:0]   fifocnt,
    input  logic [NCH-1:0]      overflow,
    output logic [NCH-1:0]      wb_cyc,
    output logic [NCH-1:0]      wb_stb,
    output logic [NCH-1:0]      wb_we,
    input  logic [NCH-1:0]      wb_ack,
    input  logic [32*NCH-1:0]   wb_dat_i,
    output logic [31:0]         out_dat,
    output logic [CHW-1:0]      out_ch,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [15:0]         ovf_cnt,
    output logic                busy
);

    localparam int               HW        = 8;
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF + GAP);
    localparam logic [7:0]       GAP_LOAD  = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0]      BURST_MAX = 16'(MAXBURST);
    localparam logic [CHW-1:0]   LAST_CH   = CHW'(NCH - 1);

    state_t          state;
    state_t          state_nx;
    logic [CHW-1:0]  ptr;
    logic [CHW-1:0]  ch;
    logic [CHW-1:0]  pick_idx;
    logic            pick_found;
    logic [NCH-1:0]  elig;
    logic [7:0]      budget;
    logic [7:0]      budget_pick;
    logic [15:0]     cnt_pick;
    logic [7:0]      gap_cnt;
    logic [HW-1:0]   holdoff [NCH];
    logic            held;
    logic            out_free;
    logic            req;
    logic            ack_g;
    logic [31:0]     dat_g;
    logic            hdr_pend;
    logic            hdr_cap;
    logic            clr_slot;
    logic            cap;
    logic [31:0]     cap_dat;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            elig[i] = (holdoff[i] == '0) && (overflow[i] || (fifocnt[i*16 +: 16] != 16'd0));
        end
    end

    rr_pick #(
        .N (NCH),
        .W (CHW)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign cnt_pick    = fifocnt[pick_idx*16 +: 16];
    assign budget_pick = (cnt_pick > BURST_MAX) ? BURST_MAX[7:0] : cnt_pick[7:0];
    assign out_free    = !out_vld || out_rdy;
    assign ack_g       = wb_ack[ch];
    assign dat_g       = wb_dat_i[ch*32 +: 32];
    assign busy        = (state != ST_IDLE);

`ifdef DRAIN_HDR_EN
    logic hdr_pend_q;
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            hdr_pend_q <= 1'b0;
        end else if (state == ST_SCAN && state_nx == ST_STROBE) begin
            hdr_pend_q <= 1'b1;
        end else if (hdr_cap) begin
            hdr_pend_q <= 1'b0;
        end
    end
    assign hdr_pend = hdr_pend_q;
    // the clear header needs the output slot, so the write strobe waits for it
    assign clr_slot = out_free;
`else
    assign hdr_pend = 1'b0;
    assign clr_slot = 1'b1;
`endif

    // once raised, a strobe stays up until ack regardless of the output side
    assign req = held
              || (state == ST_STROBE && !hdr_pend && out_free)
              || (state == ST_CLEAR && clr_slot);
    assign hdr_cap = (state == ST_STROBE) && hdr_pend && out_free;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enable || !pick_found) state_nx = ST_IDLE;
                else if (overflow[pick_idx]) state_nx = ST_CLEAR;
                else state_nx = ST_STROBE;
            end
            ST_STROBE: begin
                if (req && ack_g) begin
                    if (budget == 8'd1) state_nx = ST_DONE;
                    else if (GAP == 0) state_nx = ST_STROBE;
                    else state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) state_nx = ST_STROBE;
            end
            ST_CLEAR: begin
                if (req && ack_g) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = enable ? ST_SCAN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_cyc = '0;
        wb_stb = '0;
        wb_we  = '0;
        if (req) begin
            wb_cyc[ch] = 1'b1;
            wb_stb[ch] = 1'b1;
            wb_we[ch]  = (state == ST_CLEAR);
        end
    end

    always_comb begin
        cap     = 1'b0;
        cap_dat = dat_g;
        if (hdr_cap) begin
            cap     = 1'b1;
            cap_dat = make_hdr(HDR_TYPE_DATA, 4'(ch), {8'h00, budget});
        end else if (state == ST_STROBE && req && ack_g) begin
            cap = 1'b1;
        end
`ifdef DRAIN_HDR_EN
        else if (state == ST_CLEAR && req && ack_g) begin
            cap     = 1'b1;
            cap_dat = make_hdr(HDR_TYPE_CLEAR, 4'(ch), 16'h0000);
        end
`endif
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ptr     <= '0;
            ch      <= '0;
            budget  <= '0;
            gap_cnt <= '0;
            held    <= 1'b0;
            out_dat <= '0;
            out_ch  <= '0;
            out_vld <= 1'b0;
            ovf_cnt <= '0;
            for (int i = 0; i < NCH; i++) holdoff[i] <= '0;
        end else begin
            held <= req && !ack_g;

            for (int i = 0; i < NCH; i++) begin
                if (state == ST_DONE && ch == CHW'(i)) holdoff[i] <= HOLD_LOAD;
                else if (holdoff[i] != '0) holdoff[i] <= holdoff[i] - 1'b1;
            end

            case (state)
                ST_SCAN: begin
                    // budget is latched once; the live count is ignored for the rest of the burst
                    if (state_nx == ST_STROBE || state_nx == ST_CLEAR) begin
                        ch     <= pick_idx;
                        budget <= budget_pick;
                    end
                end
                ST_STROBE: begin
                    if (req && ack_g) begin
                        budget  <= budget - 8'd1;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                ST_CLEAR: begin
                    if (req && ack_g && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
                end
                ST_DONE: begin
                    ptr <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase

            if (cap) begin
                out_dat <= cap_dat;
                out_ch  <= ch;
                out_vld <= 1'b1;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb/tb_fifo_drain_arb.sv - scoreboard bench for fifo_drain_arb with a registered-ack FIFO model
module tb_fifo_drain_arb;

    localparam int NCH      = 4;
    localparam int CHW      = 2;
    localparam int MAXBURST = 16;
    localparam int GAP      = 3;
    localparam int HOLDOFF  = 2;

    logic                wb_clk   = 1'b0;
    logic                wb_rst_n = 1'b0;
    logic                enable   = 1'b0;
    logic [16*NCH-1:0]   fifocnt  = '0;
    logic [NCH-1:0]      overflow = '0;
    logic [NCH-1:0]      wb_ack   = '0;
    logic [32*NCH-1:0]   wb_dat_i = '0;
    logic                out_rdy  = 1'b1;
    logic [NCH-1:0]      wb_cyc;
    logic [NCH-1:0]      wb_stb;
    logic [NCH-1:0]      wb_we;
    logic [31:0]         out_dat;
    logic [CHW-1:0]      out_ch;
    logic                out_vld;
    logic [15:0]         ovf_cnt;
    logic                busy;

    fifo_drain_arb #(
        .NCH(NCH), .CHW(CHW), .MAXBURST(MAXBURST), .GAP(GAP), .HOLDOFF(HOLDOFF)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable),
        .fifocnt(fifocnt), .overflow(overflow),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_ack(wb_ack), .wb_dat_i(wb_dat_i),
        .out_dat(out_dat), .out_ch(out_ch), .out_vld(out_vld), .out_rdy(out_rdy),
        .ovf_cnt(ovf_cnt), .busy(busy)
    );

    always #5 wb_clk = ~wb_clk;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int n_out = 0;
    int viol  = 0;

    logic [CHW+31:0] sb[$];
    logic [31:0]     mem [NCH][64];
    int              cnt [NCH];
    int              rdi [NCH];
    bit              pend [NCH];
    bit              we_seen [NCH];
    int              rd_acks [NCH];
    int              wr_acks [NCH];
    int              last_ack [NCH];

    always @(posedge wb_clk) cyc_n++;

    function automatic logic [31:0] word(input int c, input int i);
        return 32'hC0DE0000 + 32'(c * 4096 + i);
    endfunction

    // FIFO model: ack arrives one full cycle after the strobe is first seen
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            if ($countones(wb_cyc) > 1) viol++;
            for (int c = 0; c < NCH; c++) begin
                if (wb_ack[c]) begin
                    wb_ack[c] = 1'b0;
                    pend[c]   = 1'b0;
                    if (we_seen[c]) begin
                        wr_acks[c]++;
                        cnt[c]      = 0;
                        overflow[c] = 1'b0;
                    end else begin
                        if (cnt[c] == 0) viol++;
                        else begin
                            cnt[c]--;
                            rdi[c]++;
                        end
                        rd_acks[c]++;
                        if (cyc_n - last_ack[c] < GAP + 2) viol++;
                        last_ack[c] = cyc_n;
                    end
                    fifocnt[c*16 +: 16] = 16'(cnt[c]);
                end else if (wb_cyc[c] && wb_stb[c]) begin
                    if (pend[c]) begin
                        wb_ack[c]  = 1'b1;
                        we_seen[c] = wb_we[c];
                        if (rdi[c] < 64) wb_dat_i[c*32 +: 32] = mem[c][rdi[c]];
                    end else begin
                        pend[c] = 1'b1;
                    end
                end else if (pend[c]) begin
                    viol++;
                end
            end
        end
    end

    always @(negedge wb_clk) begin
        if (wb_rst_n && out_vld && out_rdy) begin
            logic [CHW+31:0] exp_w;
            tests++;
            n_out++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected got ch=%0d dat=%h required none", out_ch, out_dat);
            end else begin
                exp_w = sb.pop_front();
                if ({out_ch, out_dat} !== exp_w) begin
                    fails++;
                    $display("FAIL out_word got ch=%0d dat=%h required ch=%0d dat=%h",
                             out_ch, out_dat, exp_w[CHW+31:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            cnt[c] = 0; rdi[c] = 0; pend[c] = 1'b0; we_seen[c] = 1'b0;
            rd_acks[c] = 0; wr_acks[c] = 0; last_ack[c] = -1000;
        end
        wb_ack   = '0;
        fifocnt  = '0;
        overflow = '0;
        viol     = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        out_rdy  = 1'b1;
        wb_rst_n = 1'b0;
        model_reset();
        tick(3);
        wb_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic load(input int c, input int n);
        for (int i = 0; i < n; i++) mem[c][i] = word(c, i);
        cnt[c] = n;
        rdi[c] = 0;
        fifocnt[c*16 +: 16] = 16'(n);
    endtask

    task automatic expect_words(input int c, input int first, input int n);
        for (int i = 0; i < n; i++) sb.push_back({CHW'(c), word(c, first + i)});
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            tick(1);
            k++;
        end
        tick(20);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain remaining=%0d required=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b required 0", busy); end
        tests++; if (out_vld !== 1'b0)  begin fails++; $display("FAIL reset_out_vld got %b required 0", out_vld); end
        tests++; if (out_dat !== 32'h0) begin fails++; $display("FAIL reset_out_dat got %h required 0", out_dat); end
        tests++; if (out_ch !== '0)     begin fails++; $display("FAIL reset_out_ch got %0d required 0", out_ch); end
        tests++; if (ovf_cnt !== 16'h0) begin fails++; $display("FAIL reset_ovf_cnt got %0d required 0", ovf_cnt); end
        tests++; if ({wb_cyc, wb_stb, wb_we} !== '0) begin
            fails++; $display("FAIL reset_wb got cyc=%b stb=%b we=%b required 0", wb_cyc, wb_stb, wb_we);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load(2, 3);
        expect_words(2, 0, 3);
        enable = 1'b1;
        wait_drain("basic", 400);
        tests++; if (rd_acks[2] !== 3) begin fails++; $display("FAIL basic_ch2_reads got %0d required 3", rd_acks[2]); end
        tests++; if (rd_acks[0] + rd_acks[1] + rd_acks[3] !== 0) begin
            fails++; $display("FAIL basic_other_reads got %0d required 0", rd_acks[0] + rd_acks[1] + rd_acks[3]);
        end
        tests++; if (viol !== 0) begin fails++; $display("FAIL basic_protocol got %0d violations required 0", viol); end
    endtask

    task automatic test_maxburst();
        do_reset();
        load(0, 40);
        load(1, 2);
        expect_words(0, 0, 16);
        expect_words(1, 0, 2);
        expect_words(0, 16, 16);
        expect_words(0, 32, 8);
        enable = 1'b1;
        wait_drain("maxburst", 2000);
        tests++; if (rd_acks[0] !== 40) begin fails++; $display("FAIL maxburst_ch0_reads got %0d required 40", rd_acks[0]); end
        tests++; if (rd_acks[1] !== 2)  begin fails++; $display("FAIL maxburst_ch1_reads got %0d required 2", rd_acks[1]); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL maxburst_protocol got %0d violations required 0", viol); end
    endtask

    task automatic test_ptr_order();
        do_reset();
        load(1, 1);
        expect_words(1, 0, 1);
        enable = 1'b1;
        wait_drain("ptr_setup", 300);
        enable = 1'b0;
        tick(10);
        load(1, 2);
        load(3, 2);
        expect_words(3, 0, 2);
        expect_words(1, 0, 2);
        enable = 1'b1;
        wait_drain("ptr_order", 500);
        tests++; if (rd_acks[3] !== 2) begin fails++; $display("FAIL ptr_ch3_reads got %0d required 2", rd_acks[3]); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL ptr_protocol got %0d violations required 0", viol); end
    endtask

    task automatic test_stall();
        int base;
        int k;
        int acks0;
        logic [31:0] held_dat;
        bit stable;
        do_reset();
        load(2, 6);
        expect_words(2, 0, 6);
        enable = 1'b1;
        base = n_out;
        k = 0;
        while (n_out < base + 2 && k < 300) begin tick(1); k++; end
        out_rdy = 1'b0;
        k = 0;
        while (!out_vld && k < 40) begin tick(1); k++; end
        tick(1);
        held_dat = out_dat;
        acks0    = rd_acks[2];
        stable   = 1'b1;
        repeat (20) begin
            tick(1);
            if (out_dat !== held_dat || out_vld !== 1'b1) stable = 1'b0;
        end
        tests++; if (!stable) begin fails++; $display("FAIL stall_hold got dat=%h vld=%b required dat=%h vld=1", out_dat, out_vld, held_dat); end
        tests++; if (rd_acks[2] !== acks0) begin fails++; $display("FAIL stall_no_strobe got %0d reads required %0d", rd_acks[2], acks0); end
        out_rdy = 1'b1;
        wait_drain("stall", 500);
        tests++; if (rd_acks[2] !== 6) begin fails++; $display("FAIL stall_reads got %0d required 6", rd_acks[2]); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL stall_protocol got %0d violations required 0", viol); end
    endtask

    task automatic test_overflow();
        int k = 0;
        do_reset();
        load(0, 5);
        overflow[0] = 1'b1;
        enable = 1'b1;
        while (ovf_cnt != 16'd1 && k < 200) begin tick(1); k++; end
        tick(30);
        tests++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL ovf_cnt got %0d required 1", ovf_cnt); end
        tests++; if (wr_acks[0] !== 1)  begin fails++; $display("FAIL ovf_write_strobes got %0d required 1", wr_acks[0]); end
        tests++; if (rd_acks[0] + rd_acks[1] + rd_acks[2] + rd_acks[3] !== 0) begin
            fails++; $display("FAIL ovf_reads got %0d required 0", rd_acks[0] + rd_acks[1] + rd_acks[2] + rd_acks[3]);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        load(1, 10);
        expect_words(1, 0, 10);
        enable = 1'b1;
        while (!wb_stb[1] && k < 300) begin tick(1); k++; end
        tests++;
        if (!wb_stb[1]) begin
            fails++; $display("FAIL rstmid_strobe_seen got 0 required 1");
        end
        wb_rst_n = 1'b0;
        #1;
        tests++; if ({wb_cyc, wb_stb} !== '0) begin fails++; $display("FAIL rstmid_strobes got cyc=%b stb=%b required 0", wb_cyc, wb_stb); end
        tests++; if (out_vld !== 1'b0)  begin fails++; $display("FAIL rstmid_out_vld got %b required 0", out_vld); end
        tests++; if (ovf_cnt !== 16'h0) begin fails++; $display("FAIL rstmid_ovf_cnt got %0d required 0", ovf_cnt); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rstmid_busy got %b required 0", busy); end
        enable = 1'b0;
        model_reset();
        tick(2);
        wb_rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_maxburst();
        test_ptr_order();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
